pq_sort_client: RTL and testbench



---
 rtl/pq_sort_client.sv | 127 ++++++++++++
 tb/tb_pq_sort_client.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_sort_client.sv
// Batch sorter front-end for a max priority queue: pushes an input batch into the
// queue, then pops it back out as a descending stream tagged with a last marker.
module pq_sort_client #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PQ_DEPTH   = 8,
    parameter int unsigned CNT_WIDTH  = $clog2(PQ_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] pq_data,
    output logic                  pq_valid,
    output logic [1:0]            pq_op,
    input  logic                  pq_ready,
    input  logic [DATA_WIDTH-1:0] pq_result,
    input  logic                  pq_result_valid,
    output logic                  pq_result_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_TOP  = 2'b11
    } pq_op_e;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(PQ_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAST_C  = CNT_WIDTH'(PQ_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;

    pq_op_e op_c;
    logic   push_fire;
    logic   pop_fire;

    always_comb begin
        in_ready        = 1'b0;
        pq_valid        = 1'b0;
        op_c            = OP_NOP;
        pq_result_ready = 1'b0;
        case (state_q)
            S_FILL: begin
                in_ready = pq_ready && (count_q < DEPTH_C);
                if (in_ready) begin
                    op_c     = OP_PUSH;
                    pq_valid = in_valid;
                end
            end
            S_DRAIN: begin
                op_c            = OP_POP;
                pq_result_ready = !out_valid_q || out_ready;
            end
            default: ;
        endcase
    end

    assign push_fire = in_valid && in_ready;
    assign pop_fire  = pq_result_ready && pq_result_valid;

    assign pq_op     = op_c;
    assign pq_data   = in_data;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == S_DRAIN) || (count_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_FILL;
            count_q     <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            // A pop in the same cycle below overrides this consume-side clear.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_FILL: begin
                    if (push_fire) begin
                        if (in_last || (count_q == LAST_C)) begin
                            state_q     <= S_DRAIN;
                            remaining_q <= count_q + ONE_C;
                            count_q     <= '0;
                        end else begin
                            count_q <= count_q + ONE_C;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop_fire) begin
                        out_data_q  <= pq_result;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (remaining_q == ONE_C);
                        remaining_q <= remaining_q - ONE_C;
                        if (remaining_q == ONE_C) begin
                            state_q <= S_FILL;
                        end
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_sort_client.sv
// Self-checking bench for pq_sort_client with a behavioural max-queue attached and
// a sort-based scoreboard for the expected output stream.
module tb_pq_sort_client;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int LIMIT = 2000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [DW-1:0] pq_data;
    logic          pq_valid;
    logic [1:0]    pq_op;
    logic          pq_ready = 1'b1;
    logic [DW-1:0] pq_result = '0;
    logic          pq_result_valid = 1'b0;
    logic          pq_result_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          busy;

    always #5 clk = ~clk;

    pq_sort_client #(.DATA_WIDTH(DW), .PQ_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .pq_data(pq_data), .pq_valid(pq_valid), .pq_op(pq_op), .pq_ready(pq_ready),
        .pq_result(pq_result), .pq_result_valid(pq_result_valid),
        .pq_result_ready(pq_result_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each entry is {last, data}.
    logic [8:0]    exp_q[$];
    logic [DW-1:0] cur_batch[$];
    int            cur_len = 0;
    bit            use_model = 1'b0;
    int            out_seen = 0;
    int            drain_set = 0;
    int            drain_clr = 0;
    wire           drain_exp = (drain_set != drain_clr);

    // Attached max priority queue, kept sorted largest-first.
    logic [DW-1:0] pq_q[$];
    int            hold = 0;
    int            lat_max = 0;
    bit            pq_stall_en = 1'b0;
    bit            m_push, m_pop;
    int            m_i;
    logic [DW-1:0] m_tmp;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pq_q.delete();
            hold = 0;
            pq_ready        <= 1'b1;
            pq_result_valid <= 1'b0;
            pq_result       <= '0;
        end else begin
            m_push = pq_valid && (pq_op == 2'b01) && pq_ready;
            m_pop  = pq_result_ready && pq_result_valid;
            if (m_pop) begin
                m_tmp = pq_q.pop_front();
                if (pq_q.size() == 0) drain_clr++;
            end
            if (m_push) begin
                m_i = 0;
                while (m_i < pq_q.size() && pq_q[m_i] >= pq_data) m_i++;
                pq_q.insert(m_i, pq_data);
            end
            if (m_push || m_pop) hold = $urandom_range(0, lat_max);
            else if (hold > 0) hold--;
            pq_ready        <= (pq_q.size() < DEPTH) && !(pq_stall_en && $urandom_range(0, 3) == 0);
            pq_result       <= (pq_q.size() > 0) ? pq_q[0] : '0;
            pq_result_valid <= (pq_q.size() > 0) && (hold == 0);
        end
    end

    // out_ready shaping: 0 always, 1 random, 2 toggle, 3 low for hold_cnt valid cycles.
    int rmode = 0;
    int hold_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: out_ready = !out_ready;
            default: begin
                if (hold_cnt > 0) begin
                    out_ready = 1'b0;
                    if (out_valid) hold_cnt--;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [8:0]    e;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got %0d expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[7:0]));
                    chk("out_last", 32'(out_last), 32'(e[8]));
                end
            end
            if (drain_exp)
                chk("drain_ctl", 32'({in_ready, pq_valid, pq_op, pq_result_ready}),
                    32'({1'b0, 1'b0, 2'b10, (!out_valid || out_ready)}));
            else
                chk("fill_ctl", 32'({in_ready, pq_valid, pq_op, pq_result_ready}),
                    32'({pq_ready, in_valid && pq_ready, (pq_ready ? 2'b01 : 2'b00), 1'b0}));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic send(input logic [DW-1:0] d, input bit last, input int gap);
        int t;
        bit batch_end;
        repeat (gap) begin @(posedge clk); #1; end
        in_data = d; in_valid = 1'b1; in_last = last;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < LIMIT) begin @(negedge clk); t++; end
        chk("in_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        if (t < LIMIT) begin
            cur_len++;
            batch_end = last || (cur_len == DEPTH);
            if (use_model) cur_batch.push_back(d);
            if (batch_end) begin
                drain_set++;
                cur_len = 0;
                if (use_model) begin
                    cur_batch.rsort();
                    foreach (cur_batch[k]) exp_q.push_back({(k == cur_batch.size() - 1), cur_batch[k]});
                    cur_batch.delete();
                end
            end
        end
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || drain_exp) && t < LIMIT) begin @(negedge clk); t++; end
        chk("drain_done", 32'(t < LIMIT), 32'd1);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [0:9][7:0] din;
        logic [0:9]      dlast;
        int              n;
        logic [0:9][7:0] dout;
        logic [0:9]      olast;
        int              nout;
        int              rm;
        int              hold;
    } vec_t;
    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{din: {8'd5, 8'd200, 8'd17, 8'd99, 8'd3, 40'h0}, dlast: 10'b0000100000, n: 5,
                  dout: {8'd200, 8'd99, 8'd17, 8'd5, 8'd3, 40'h0}, olast: 10'b0000100000, nout: 5, rm: 0, hold: 0};
        vt[1] = '{din: {8'd42, 72'h0}, dlast: 10'b1000000000, n: 1,
                  dout: {8'd42, 72'h0}, olast: 10'b1000000000, nout: 1, rm: 0, hold: 0};
        vt[2] = '{din: {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, dlast: 10'b0000000001, n: 10,
                  dout: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd9, 8'd8}, olast: 10'b0000000101, nout: 10,
                  rm: 0, hold: 0};
        vt[3] = '{din: {8'd8, 8'd8, 8'd1, 8'd8, 48'h0}, dlast: 10'b0001000000, n: 4,
                  dout: {8'd8, 8'd8, 8'd8, 8'd1, 48'h0}, olast: 10'b0001000000, nout: 4, rm: 2, hold: 0};
        vt[4] = '{din: {8'd3, 8'd1, 8'd7, 8'd9, 48'h0}, dlast: 10'b0101000000, n: 4,
                  dout: {8'd3, 8'd1, 8'd9, 8'd7, 48'h0}, olast: 10'b0101000000, nout: 4, rm: 3, hold: 4};

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        use_model = 1'b0;
        for (int v = 0; v < 5; v++) begin
            rmode = vt[v].rm;
            hold_cnt = vt[v].hold;
            for (int o = 0; o < vt[v].nout; o++) exp_q.push_back({vt[v].olast[o], vt[v].dout[o]});
            for (int i = 0; i < vt[v].n; i++) send(vt[v].din[i], vt[v].dlast[i], 0);
            wait_idle();
        end

        // Reset while draining, then confirm a fresh batch sorts normally.
        use_model = 1'b1;
        rmode = 0;
        begin
            int base, t;
            base = out_seen;
            send(8'd10, 1'b0, 0); send(8'd50, 1'b0, 0); send(8'd30, 1'b0, 0);
            send(8'd20, 1'b0, 0); send(8'd40, 1'b1, 0);
            t = 0;
            while (out_seen < base + 2 && t < LIMIT) begin @(negedge clk); t++; end
            chk("pre_reset_pops", 32'(out_seen >= base + 2), 32'd1);
            #2;
            reset_n = 1'b0;
            exp_q.delete(); cur_batch.delete(); cur_len = 0; drain_set = drain_clr;
            #1;
            chk("midrst_out_valid", 32'(out_valid), 32'd0);
            chk("midrst_busy", 32'(busy), 32'd0);
            @(negedge clk); reset_n = 1'b1;
            @(posedge clk); #1;
            send(8'd4, 1'b0, 0); send(8'd6, 1'b1, 0);
            wait_idle();
        end

        // Randomized batches with queue latency, queue backpressure and output stalls.
        rmode = 1; lat_max = 2; pq_stall_en = 1'b1;
        for (int b = 0; b < 25; b++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                logic [DW-1:0] d;
                d = (b % 2 == 1) ? DW'($urandom_range(0, 7)) : DW'($urandom_range(0, 255));
                send(d, (i == len - 1) && ($urandom_range(0, 4) != 0), $urandom_range(0, 2));
            end
        end
        send(8'd77, 1'b1, 0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
